if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction fetch stage that consumes the PC from the PC generator, fetches over a req/ack port to instruction memory and loads the IF/ID pipeline register. It returns `pc_plus_1_if` to the PC generator and tells the controller when the PC must hold. A four-state FSM with a one-entry hold buffer absorbs variable memory latency, downstream stalls and redirect flushes. The PC is word-addressed: the next sequential PC is pc + 1.

## Interface
- `RESET_INSTR`, 32'h0000_0000: value loaded into `instr_id` on reset and flush (NOP).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `pc`  in  32  current PC from the PC generator.
- `pc_plus_1_if`  out  32  combinational pc + 1, mod 2^32.
- `imem_req`  out  1  fetch request, level.
- `imem_addr`  out  32  fetch word address.
- `imem_ack`  in  1  data valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `stall_if`  in  1  ID cannot accept; hold the IF/ID register.
- `flush_if`  in  1  redirect taken in ID; squash IF/ID and any in-flight fetch.
- `fetch_busy`  out  1  controller ORs this into `stall_pc`.
- `instr_id`  out  32  IF/ID instruction.
- `pc_plus_1_id`  out  32  IF/ID pc + 1.
- `valid_id`  out  1  IF/ID holds a real instruction.

## Operation
- **Reset values.** While `rst` is low: state FETCH, `imem_req`=0, `valid_id`=0, `instr_id`=`RESET_INSTR`, `pc_plus_1_id`=0, hold buffer empty. `imem_req` first rises in the cycle after `rst` is released.
- **FETCH.**
  - `imem_req`=1 and `imem_addr`=`pc`; `pc` is latched into `req_addr`.
  - ack and no stall: load IF/ID with {rdata, pc+1, valid=1}; `fetch_busy`=0; stay in FETCH.
  - ack and `stall_if`: put the data in the hold buffer, go to HOLD; `fetch_busy`=1.
  - no ack: go to WAIT; `fetch_busy`=1.
- **WAIT.** `imem_req` stays 1 and `imem_addr`=`req_addr`, which is stable. On ack, behave as FETCH-with-ack (load IF/ID, or go to HOLD if stalled) and return to FETCH. `fetch_busy`=1 until the cycle of the ack-and-accept.
- **HOLD.** `imem_req`=0 and `fetch_busy`=1. When `stall_if` falls, move the buffer into IF/ID and go to FETCH.
- **DROP.** Entered on `flush_if` while in WAIT. A request cannot be withdrawn, so `imem_req` stays 1 until ack. The returned data is discarded, then the FSM goes to FETCH and fetches from the redirected `pc`.
- **IF/ID while `stall_if`=1.** Contents are held unchanged, including `valid_id`.
- **Flush priority.** `flush_if` beats `stall_if` and beats ack.
  - Next edge: `valid_id`=0, `instr_id`=`RESET_INSTR`, hold buffer cleared.
  - From FETCH or HOLD: go to FETCH. From WAIT: go to DROP (in DROP, flush changes nothing).
  - An ack arriving in the flush cycle is discarded.
- **Controller contract.** The controller loads the redirect PC on `flush_if` regardless of `fetch_busy`. Otherwise `stall_pc` = `fetch_busy` | load-use stall.
- **Wrap.** `pc`=32'hFFFF_FFFF gives `pc_plus_1_if`=0.
- **Reset mid-WAIT or mid-DROP.** The request is abandoned and `imem_req` drops asynchronously. Instruction memory must ignore an ack for an abandoned request.

## Timing
- `pc_plus_1_if`: combinational, zero latency.
- Zero-wait memory (ack in the request cycle): one instruction per cycle; IF/ID updates at the edge ending the request cycle.
- N-cycle ack: the instruction appears in IF/ID one edge after the ack cycle; `fetch_busy` is high for the N cycles from request to ack.
- Flush: `valid_id` low after exactly one edge. The first post-redirect instruction reaches IF/ID no earlier than 2 edges after the flush cycle, or after the in-flight ack + 1 fetch when in DROP.
- `imem_addr` must not change while `imem_req`=1 and no ack has arrived.

## Structure
- Shared package `if_pkg`: FSM state enum {FETCH, WAIT, HOLD, DROP} as 2-bit, and the NOP constant.
- One sub-module, `if_hold_buf`: a one-entry buffer of {instr, pc+1} with load/clear/valid.
- The FSM and the IF/ID register stay in `if_fetch_stage`.

## Test plan
- **Zero-wait stream.** ack tied 1, rdata=pc^32'hA5A5_0000, `pc` 0→1→2 → `instr_id` sequence 32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0002 on consecutive edges; `fetch_busy` stays 0.
- **3-cycle latency.** pc=0x10, ack in cycle 3 → `fetch_busy` high cycles 0–2 and `imem_addr`=0x10 throughout; `pc_plus_1_id`=0x11, valid at edge 4.
- **Stall on ack.** ack with `stall_if`=1 for 2 cycles → IF/ID unchanged and FSM in HOLD; data enters IF/ID one edge after the stall drops.
- **Flush while waiting.** flush in WAIT for addr 0x20, pc redirected to 0x80, ack 2 cycles later with 0xDEAD → 0xDEAD never valid; next request addr 0x80.
- **Flush + stall + ack same cycle.** → `valid_id`=0, `instr_id`=0, FSM in FETCH.
- **Reset mid-WAIT, plus wrap.** `rst` low mid-WAIT → `imem_req`=0 asynchronously, all outputs at reset values. Separately, pc=32'hFFFF_FFFF → `pc_plus_1_if`=0.

Source files
------------

// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction fetch stage:
//   - if_state_e  : fetch FSM state encoding (2 bits)
//   - RESET_INSTR : NOP word loaded into IF/ID on reset and flush
//   - next_word() : word-addressed sequential successor (wraps mod 2^32)
// ---------------------------------------------------------------------------
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // issue a request for the current pc
    WAIT  = 2'd1,  // request outstanding, address frozen
    HOLD  = 2'd2,  // fetched word parked while ID is stalled
    DROP  = 2'd3   // request outstanding but squashed by a redirect
  } if_state_e;

  localparam logic [31:0] RESET_INSTR = 32'h0000_0000;

  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd1;
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// ---------------------------------------------------------------------------
// if_hold_buf
// One-entry buffer holding {instr, pc+1} for a word that came back from
// memory while ID was stalled. clear has priority over load.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   load                   capture instr_in / pc_plus_1_in
//   clear                  empty the buffer
//   instr_in, pc_plus_1_in data to capture
//   valid                  buffer holds an entry
//   instr, pc_plus_1       buffered contents
// ---------------------------------------------------------------------------
module if_hold_buf
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_plus_1_in,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc_plus_1
);

  logic        valid_d, valid_q;
  logic [31:0] instr_d, instr_q;
  logic [31:0] pc1_d, pc1_q;

  // Next buffer contents: clear wins, then load, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    if (clear) begin
      valid_d = 1'b0;
      instr_d = RESET_INSTR;
      pc1_d   = 32'd0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = instr_in;
      pc1_d   = pc_plus_1_in;
    end else begin
      valid_d = valid_q;
    end
  end

  // Buffer storage with asynchronous reset to empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      instr_q <= RESET_INSTR;
      pc1_q   <= 32'd0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
    end
  end

  assign valid     = valid_q;
  assign instr     = instr_q;
  assign pc_plus_1 = pc1_q;

endmodule

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
// Fetches the instruction at pc over a req/ack memory port and loads the
// IF/ID pipeline register. A four-state FSM (FETCH/WAIT/HOLD/DROP) plus a
// one-entry hold buffer absorbs memory latency, ID stalls and redirects.
// Ports:
//   clk, rst           clock, asynchronous active-low reset
//   pc                 current PC (word address)
//   pc_plus_1_if       combinational pc + 1 back to the PC generator
//   imem_req/addr      fetch request (level) and word address
//   imem_ack/rdata     memory response
//   stall_if           ID cannot accept; IF/ID holds
//   flush_if           redirect; squash IF/ID and any in-flight fetch
//   fetch_busy         PC must hold (ORed into stall_pc by the controller)
//   instr_id, pc_plus_1_id, valid_id   IF/ID register
// ---------------------------------------------------------------------------
module if_fetch_stage
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] pc_plus_1_if,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_if,
  input  logic        flush_if,
  output logic        fetch_busy,
  output logic [31:0] instr_id,
  output logic [31:0] pc_plus_1_id,
  output logic        valid_id
);

  if_state_e   state_d, state_q;
  // Low for the first cycle after reset so the request rises one cycle
  // after release and drops asynchronously when reset asserts.
  logic        started_d, started_q;
  logic [31:0] req_addr_d, req_addr_q;
  logic [31:0] instr_id_d, instr_id_q;
  logic [31:0] pc1_id_d, pc1_id_q;
  logic        valid_id_d, valid_id_q;

  logic        hb_load_s, hb_clear_s, hb_valid_s;
  logic [31:0] hb_instr_s, hb_pc1_s;
  logic [31:0] fetch_addr_s, fetch_pc1_s;
  logic        req_s, busy_s;
  logic        bubble_valid_s;

  assign pc_plus_1_if = next_word(pc);

  // A new request presents pc directly; once outstanding the latched
  // address is used so imem_addr cannot move before the ack.
  assign fetch_addr_s   = (state_q == FETCH) ? pc : req_addr_q;
  assign fetch_pc1_s    = next_word(fetch_addr_s);
  // Nothing new for ID: keep IF/ID if ID is stalled, else insert a bubble.
  assign bubble_valid_s = stall_if ? valid_id_q : 1'b0;

  if_hold_buf u_hold_buf (
    .clk          (clk),
    .rst          (rst),
    .load         (hb_load_s),
    .clear        (hb_clear_s),
    .instr_in     (imem_rdata),
    .pc_plus_1_in (fetch_pc1_s),
    .valid        (hb_valid_s),
    .instr        (hb_instr_s),
    .pc_plus_1    (hb_pc1_s)
  );

  // FSM next state, request/busy outputs and IF/ID + hold buffer control.
  always_comb begin
    state_d    = state_q;
    started_d  = 1'b1;
    req_addr_d = req_addr_q;
    instr_id_d = instr_id_q;
    pc1_id_d   = pc1_id_q;
    valid_id_d = valid_id_q;
    hb_load_s  = 1'b0;
    hb_clear_s = 1'b0;
    req_s      = 1'b0;
    busy_s     = 1'b1;
    case (state_q)
      FETCH: begin
        req_s      = started_q;
        req_addr_d = pc;
        if (!started_q) begin
          valid_id_d = bubble_valid_s;
        end else if (flush_if) begin
          // Flush beats stall and ack; any returned word is discarded.
          valid_id_d = 1'b0;
          instr_id_d = RESET_INSTR;
          hb_clear_s = 1'b1;
        end else if (imem_ack) begin
          if (stall_if) begin
            hb_load_s = 1'b1;
            state_d   = HOLD;
          end else begin
            instr_id_d = imem_rdata;
            pc1_id_d   = fetch_pc1_s;
            valid_id_d = 1'b1;
            busy_s     = 1'b0;
          end
        end else begin
          state_d    = WAIT;
          valid_id_d = bubble_valid_s;
        end
      end
      WAIT: begin
        req_s = 1'b1;
        if (flush_if) begin
          // The request cannot be withdrawn; wait out its ack in DROP.
          state_d    = DROP;
          valid_id_d = 1'b0;
          instr_id_d = RESET_INSTR;
          hb_clear_s = 1'b1;
        end else if (imem_ack) begin
          if (stall_if) begin
            hb_load_s = 1'b1;
            state_d   = HOLD;
          end else begin
            state_d    = FETCH;
            instr_id_d = imem_rdata;
            pc1_id_d   = fetch_pc1_s;
            valid_id_d = 1'b1;
            busy_s     = 1'b0;
          end
        end else begin
          valid_id_d = bubble_valid_s;
        end
      end
      HOLD: begin
        if (flush_if) begin
          state_d    = FETCH;
          valid_id_d = 1'b0;
          instr_id_d = RESET_INSTR;
          hb_clear_s = 1'b1;
        end else if (!stall_if) begin
          // The parked word is accepted now, so the PC may advance.
          state_d    = FETCH;
          instr_id_d = hb_instr_s;
          pc1_id_d   = hb_pc1_s;
          valid_id_d = hb_valid_s;
          hb_clear_s = 1'b1;
          busy_s     = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      DROP: begin
        req_s      = 1'b1;
        valid_id_d = bubble_valid_s;
        if (imem_ack) begin
          state_d = FETCH;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d    = FETCH;
        valid_id_d = 1'b0;
        instr_id_d = RESET_INSTR;
        hb_clear_s = 1'b1;
      end
    endcase
  end

  // State, request address and IF/ID register with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      started_q  <= 1'b0;
      req_addr_q <= 32'd0;
      instr_id_q <= RESET_INSTR;
      pc1_id_q   <= 32'd0;
      valid_id_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      started_q  <= started_d;
      req_addr_q <= req_addr_d;
      instr_id_q <= instr_id_d;
      pc1_id_q   <= pc1_id_d;
      valid_id_q <= valid_id_d;
    end
  end

  assign imem_req     = req_s;
  assign imem_addr    = fetch_addr_s;
  assign fetch_busy   = busy_s;
  assign instr_id     = instr_id_q;
  assign pc_plus_1_id = pc1_id_q;
  assign valid_id     = valid_id_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed stimulus for if_fetch_stage. A transaction-level model (one
// outstanding request, a queue of parked words, an IF/ID record) is checked
// against the DUT on every falling edge; hand-computed literals in the
// stimulus sequence pin the model.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_plus_1_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall_if;
  logic        flush_if;
  logic        fetch_busy;
  logic [31:0] instr_id;
  logic [31:0] pc_plus_1_id;
  logic        valid_id;

  int n_tests = 0;
  int n_fail  = 0;

  if_fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .pc_plus_1_if (pc_plus_1_if),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stall_if     (stall_if),
    .flush_if     (flush_if),
    .fetch_busy   (fetch_busy),
    .instr_id     (instr_id),
    .pc_plus_1_id (pc_plus_1_id),
    .valid_id     (valid_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc1;
  } ent_t;

  ent_t        m_buf[$];       // words fetched but not yet accepted by ID
  logic        m_started;      // a request may be issued this cycle
  logic        m_out;          // a request is outstanding from an earlier cycle
  logic        m_drop;         // outstanding request was squashed
  logic [31:0] m_out_addr;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc1;

  always @(negedge clk) begin : cmp
    logic        e_req;
    logic        e_busy;
    logic [31:0] a;
    ent_t        e;
    if (!rst) begin
      m_buf.delete();
      m_started  = 1'b0;
      m_out      = 1'b0;
      m_drop     = 1'b0;
      m_out_addr = 32'd0;
      m_valid    = 1'b0;
      m_instr    = 32'd0;
      m_pc1      = 32'd0;
      ck("rst_req",   {31'd0, imem_req}, 32'd0);
      ck("rst_valid", {31'd0, valid_id}, 32'd0);
      ck("rst_instr", instr_id, 32'd0);
      ck("rst_pc1",   pc_plus_1_id, 32'd0);
    end else begin
      a      = m_out ? m_out_addr : pc;
      e_req  = m_started && (m_buf.size() == 0);
      e_busy = 1'b1;
      ck("m_valid", {31'd0, valid_id}, {31'd0, m_valid});
      ck("m_instr", instr_id, m_instr);
      ck("m_pc1_id", pc_plus_1_id, m_pc1);
      ck("m_pc1_if", pc_plus_1_if, pc + 32'd1);
      ck("m_req", {31'd0, imem_req}, {31'd0, e_req});
      if (e_req) ck("m_addr", imem_addr, a);
      // what the coming edge does
      if (!m_started) begin
        m_started = 1'b1;
        if (!stall_if) m_valid = 1'b0;
      end else if (m_buf.size() != 0) begin
        if (flush_if) begin
          m_buf.delete();
          m_valid = 1'b0;
          m_instr = 32'd0;
        end else if (!stall_if) begin
          e       = m_buf.pop_front();
          m_valid = 1'b1;
          m_instr = e.instr;
          m_pc1   = e.pc1;
          e_busy  = 1'b0;
        end
      end else if (m_drop) begin
        if (imem_ack) begin
          m_out  = 1'b0;
          m_drop = 1'b0;
        end
        if (!stall_if) m_valid = 1'b0;
      end else if (flush_if) begin
        m_valid = 1'b0;
        m_instr = 32'd0;
        m_drop  = m_out;
      end else if (imem_ack) begin
        m_out = 1'b0;
        if (stall_if) begin
          m_buf.push_back({imem_rdata, a + 32'd1});
        end else begin
          m_valid = 1'b1;
          m_instr = imem_rdata;
          m_pc1   = a + 32'd1;
          e_busy  = 1'b0;
        end
      end else begin
        m_out      = 1'b1;
        m_out_addr = a;
        if (!stall_if) m_valid = 1'b0;
      end
      ck("m_busy", {31'd0, fetch_busy}, {31'd0, e_busy});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [31:0] p, input logic a, input logic [31:0] d,
                      input logic s, input logic f);
    @(posedge clk);
    #1;
    pc         = p;
    imem_ack   = a;
    imem_rdata = d;
    stall_if   = s;
    flush_if   = f;
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    pc         = 32'd0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    stall_if   = 1'b0;
    flush_if   = 1'b0;
    #2;
    ck("reset_req",   {31'd0, imem_req}, 32'd0);
    ck("reset_valid", {31'd0, valid_id}, 32'd0);
    ck("reset_instr", instr_id, 32'h0000_0000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 ck("req_cycle_after_release", {31'd0, imem_req}, 32'd0);

    // zero-wait stream
    step(32'd0, 1'b1, 32'hA5A5_0000, 1'b0, 1'b0);
    ck("zw_req", {31'd0, imem_req}, 32'd1);
    ck("zw_busy0", {31'd0, fetch_busy}, 32'd0);
    step(32'd1, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    ck("zw_instr0", instr_id, 32'hA5A5_0000);
    ck("zw_pc1_0", pc_plus_1_id, 32'd1);
    ck("zw_busy1", {31'd0, fetch_busy}, 32'd0);
    step(32'd2, 1'b1, 32'hA5A5_0002, 1'b0, 1'b0);
    ck("zw_instr1", instr_id, 32'hA5A5_0001);
    ck("zw_busy2", {31'd0, fetch_busy}, 32'd0);

    // 3-cycle latency at 0x10
    step(32'h10, 1'b0, 32'd0, 1'b0, 1'b0);
    ck("zw_instr2", instr_id, 32'hA5A5_0002);
    ck("lat_busy_c0", {31'd0, fetch_busy}, 32'd1);
    ck("lat_addr_c0", imem_addr, 32'h10);
    step(32'h10, 1'b0, 32'd0, 1'b0, 1'b0);
    ck("lat_busy_c1", {31'd0, fetch_busy}, 32'd1);
    ck("lat_addr_c1", imem_addr, 32'h10);
    ck("lat_bubble", {31'd0, valid_id}, 32'd0);
    step(32'h10, 1'b0, 32'd0, 1'b0, 1'b0);
    ck("lat_busy_c2", {31'd0, fetch_busy}, 32'd1);
    ck("lat_addr_c2", imem_addr, 32'h10);
    step(32'h10, 1'b1, 32'h1234_0010, 1'b0, 1'b0);
    ck("lat_busy_c3", {31'd0, fetch_busy}, 32'd0);

    // stall on ack for two cycles
    step(32'h11, 1'b1, 32'hBEEF_0011, 1'b1, 1'b0);
    ck("lat_pc1_edge4", pc_plus_1_id, 32'h11);
    ck("lat_valid_edge4", {31'd0, valid_id}, 32'd1);
    ck("lat_instr_edge4", instr_id, 32'h1234_0010);
    step(32'h11, 1'b0, 32'd0, 1'b1, 1'b0);
    ck("hold_req", {31'd0, imem_req}, 32'd0);
    ck("hold_busy", {31'd0, fetch_busy}, 32'd1);
    ck("hold_instr", instr_id, 32'h1234_0010);
    step(32'h11, 1'b0, 32'd0, 1'b0, 1'b0);
    ck("hold_instr2", instr_id, 32'h1234_0010);
    ck("hold_exit_req", {31'd0, imem_req}, 32'd0);
    step(32'h12, 1'b1, 32'hBEEF_0012, 1'b0, 1'b0);
    ck("hold_release_instr", instr_id, 32'hBEEF_0011);
    ck("hold_release_pc1", pc_plus_1_id, 32'h12);
    ck("refetch_addr", imem_addr, 32'h12);

    // flush while waiting on 0x20, redirect to 0x80
    step(32'h20, 1'b0, 32'd0, 1'b0, 1'b0);
    ck("pre_flush_instr", instr_id, 32'hBEEF_0012);
    step(32'h20, 1'b0, 32'd0, 1'b0, 1'b1);
    ck("flush_cycle_addr", imem_addr, 32'h20);
    step(32'h80, 1'b0, 32'd0, 1'b0, 1'b0);
    ck("drop_valid", {31'd0, valid_id}, 32'd0);
    ck("drop_instr", instr_id, 32'd0);
    ck("drop_req", {31'd0, imem_req}, 32'd1);
    ck("drop_addr", imem_addr, 32'h20);
    step(32'h80, 1'b1, 32'h0000_DEAD, 1'b0, 1'b0);
    ck("drop_ack_addr", imem_addr, 32'h20);
    step(32'h80, 1'b1, 32'h0000_C080, 1'b0, 1'b0);
    ck("dead_not_valid", {31'd0, valid_id}, 32'd0);
    ck("redirect_addr", imem_addr, 32'h80);
    step(32'h81, 1'b0, 32'd0, 1'b0, 1'b0);
    ck("redirect_instr", instr_id, 32'h0000_C080);
    ck("redirect_pc1", pc_plus_1_id, 32'h81);
    step(32'h81, 1'b1, 32'h0000_C081, 1'b0, 1'b0);

    // flush + stall + ack in one cycle
    step(32'h82, 1'b1, 32'h0000_FACE, 1'b1, 1'b1);
    ck("pre_fsa_valid", {31'd0, valid_id}, 32'd1);
    ck("pre_fsa_instr", instr_id, 32'h0000_C081);
    step(32'h90, 1'b0, 32'd0, 1'b0, 1'b0);
    ck("fsa_valid", {31'd0, valid_id}, 32'd0);
    ck("fsa_instr", instr_id, 32'd0);
    ck("fsa_fetch_addr", imem_addr, 32'h90);

    // reset in the middle of WAIT
    step(32'h90, 1'b0, 32'd0, 1'b0, 1'b0);
    ck("wait_req", {31'd0, imem_req}, 32'd1);
    #1 rst = 1'b0;
    #1;
    ck("async_req", {31'd0, imem_req}, 32'd0);
    ck("async_valid", {31'd0, valid_id}, 32'd0);
    ck("async_pc1", pc_plus_1_id, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b1;
    pc       = 32'hFFFF_FFFF;
    imem_ack = 1'b0;
    #1;
    ck("wrap_pc1_if", pc_plus_1_if, 32'd0);
    ck("rerelease_req", {31'd0, imem_req}, 32'd0);
    step(32'hFFFF_FFFF, 1'b1, 32'h7777_7777, 1'b0, 1'b0);
    ck("wrap_req_addr", imem_addr, 32'hFFFF_FFFF);
    step(32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    ck("wrap_instr", instr_id, 32'h7777_7777);
    ck("wrap_pc1_id", pc_plus_1_id, 32'd0);
    ck("wrap_valid", {31'd0, valid_id}, 32'd1);
    step(32'd0, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
    step(32'd1, 1'b0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
